// File: rtl/shift_frame_sequencer_pkg.sv
// Shared constants and state encoding for the shift-register frame sequencer.
// Optional parity support is enabled with SHIFT_FRAME_PARITY_EN.
package shift_frame_sequencer_pkg;
  localparam int   DATA_BITS   = 8;
  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
`ifdef SHIFT_FRAME_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd5
  } state_e;
endpackage

// File: rtl/shift_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, with a synchronous
// clear and a last-cycle decode. Shared with the receive-side sequencer.
module shift_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic last_o
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == LAST);
endmodule

// File: rtl/shift_frame_sequencer.sv
// Drives Load/Shift of an external 8-bit shift register and frames its serial
// output (start, 8 data MSB first, [parity], stop). Parity: SHIFT_FRAME_PARITY_EN.
module shift_frame_sequencer
  import shift_frame_sequencer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int ODD_PARITY   = 0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] TxData,
  input  logic       TxValid,
  output logic       TxReady,
  output logic [7:0] LoadIn,
  output logic       Load,
  output logic       Shift,
  input  logic       SerIn,
  output logic       LineOut,
  output logic       Busy
);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] load_in_q, load_in_d;
  logic       tmr_clr, bit_last;

  assign tmr_clr = (state_q == ST_IDLE) || (state_q == ST_LOAD);

  shift_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr_i (tmr_clr),
    .last_o(bit_last)
  );

`ifdef SHIFT_FRAME_PARITY_EN
  // first_q marks the first cycle of each data bit, where SerIn is sampled
  logic par_q, par_d, first_q, first_d;

  always_comb begin
    par_d   = par_q;
    first_d = bit_last && (state_q == ST_START || state_q == ST_DATA);
    if (state_q == ST_LOAD) par_d = 1'b0;
    else if (state_q == ST_DATA && first_q) par_d = par_q ^ SerIn;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      par_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      par_q   <= par_d;
      first_q <= first_d;
    end
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      load_in_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      load_in_q <= load_in_d;
    end
  end

  // bit_cnt_q counts data bits in DATA and stop bits in STOP
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    load_in_d = load_in_q;
    case (state_q)
      ST_IDLE: if (TxValid) begin
        load_in_d = TxData;
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        bit_cnt_d = '0;
        state_d   = ST_START;
      end
      ST_START: if (bit_last) state_d = ST_DATA;
      ST_DATA: if (bit_last) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef SHIFT_FRAME_PARITY_EN
        if (bit_cnt_q == LAST_BIT) state_d = ST_PARITY;
`else
        if (bit_cnt_q == LAST_BIT) state_d = ST_STOP;
`endif
      end
`ifdef SHIFT_FRAME_PARITY_EN
      ST_PARITY: if (bit_last) state_d = ST_STOP;
`endif
      ST_STOP: if (bit_last) begin
        if (bit_cnt_q == STOP_LAST) begin
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift on the last START cycle pre-loads SerIn with bit7; none after bit 7
  always_comb begin
    TxReady = (state_q == ST_IDLE);
    Busy    = (state_q != ST_IDLE);
    Load    = (state_q == ST_LOAD);
    Shift   = bit_last && ((state_q == ST_START) ||
              (state_q == ST_DATA && bit_cnt_q != LAST_BIT));
    LineOut = LINE_IDLE;
    case (state_q)
      ST_START:  LineOut = START_LEVEL;
      ST_DATA:   LineOut = SerIn;
`ifdef SHIFT_FRAME_PARITY_EN
      ST_PARITY: LineOut = par_q ^ (ODD_PARITY != 0);
`endif
      ST_STOP:   LineOut = STOP_LEVEL;
      default:   LineOut = LINE_IDLE;
    endcase
  end

  assign LoadIn = load_in_q;
endmodule

// File: tb/tb_shift_frame_sequencer.sv
// Directed bench: two sequencers (C=4/S=1/even, C=3/S=2/odd) each driving a
// behavioural shift register; line waveform checked cycle by cycle.
module tb_shift_frame_sequencer;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  logic       va = 1'b0, vb = 1'b0;
  logic [7:0] da = 8'h00, db = 8'h00;
  logic       rdy_a, busy_a, ld_a, sh_a, line_a, ser_a;
  logic       rdy_b, busy_b, ld_b, sh_b, line_b, ser_b;
  logic [7:0] li_a, li_b, sr_a, sr_b;

  int checks = 0;
  int failures = 0;

  shift_frame_sequencer #(.CLKS_PER_BIT(4), .STOP_BITS(1), .ODD_PARITY(0)) u_dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .TxData(da), .TxValid(va), .TxReady(rdy_a),
    .LoadIn(li_a), .Load(ld_a), .Shift(sh_a), .SerIn(ser_a), .LineOut(line_a), .Busy(busy_a));

  shift_frame_sequencer #(.CLKS_PER_BIT(3), .STOP_BITS(2), .ODD_PARITY(1)) u_dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .TxData(db), .TxValid(vb), .TxReady(rdy_b),
    .LoadIn(li_b), .Load(ld_b), .Shift(sh_b), .SerIn(ser_b), .LineOut(line_b), .Busy(busy_b));

  // shift register: registered MSB output, zero shifted in
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sr_a <= '0; ser_a <= 1'b0; sr_b <= '0; ser_b <= 1'b0;
    end else begin
      if (ld_a) sr_a <= li_a;
      else if (sh_a) begin ser_a <= sr_a[7]; sr_a <= {sr_a[6:0], 1'b0}; end
      if (ld_b) sr_b <= li_b;
      else if (sh_b) begin ser_b <= sr_b[7]; sr_b <= {sr_b[6:0], 1'b0}; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with TxValid already high; runs one frame through the
  // following IDLE cycle. hold keeps TxValid up and scribbles TxData until nxt.
  task automatic frame(input bit sel, input logic [7:0] b, input bit hold, input logic [7:0] nxt);
    int c = sel ? 3 : 4;
    int s = sel ? 2 : 1;
    bit odd = sel;
    int p = 0;
    int len, k, nld, nsh, nboth, nbusy;
    logic e, ln, ld, sh;
`ifdef SHIFT_FRAME_PARITY_EN
    p = 1;
`endif
    len = 1 + (9 + p + s) * c;
    nld = 0; nsh = 0; nboth = 0; nbusy = 0;
    chk("ready_before", sel ? rdy_b : rdy_a, 1);
    @(posedge Clk);
    for (int i = 0; i < len; i++) begin
      @(negedge Clk);
      ln = sel ? line_b : line_a;
      ld = sel ? ld_b : ld_a;
      sh = sel ? sh_b : sh_a;
      if (i == 0) chk("loadin", sel ? li_b : li_a, b);
      if (i == 0) e = 1'b1;
      else if (i <= c) e = 1'b0;
      else if (i <= 9 * c) begin k = 7 - (i - 1 - c) / c; e = b[k]; end
      else if (p == 1 && i <= 10 * c) e = (^b) ^ odd;
      else e = 1'b1;
      chk($sformatf("line[%0d] byte %0h", i, b), ln, e);
      nld += ld; nsh += sh; nboth += (ld & sh); nbusy += (sel ? busy_b : busy_a);
      if (!hold && i == 0) begin if (sel) vb = 1'b0; else va = 1'b0; end
      if (hold) begin
        if (sel) db = (i >= len - 1) ? nxt : (8'h3C ^ 8'(i));
        else     da = (i >= len - 1) ? nxt : (8'h3C ^ 8'(i));
      end
    end
    chk("load_pulses", nld, 1);
    chk("shift_pulses", nsh, 8);
    chk("load_shift_overlap", nboth, 0);
    chk("busy_cycles", nbusy, len);
    @(negedge Clk);
    chk("idle_ready", sel ? rdy_b : rdy_a, 1);
    chk("idle_busy", sel ? busy_b : busy_a, 0);
    chk("idle_line", sel ? line_b : line_a, 1);
    chk("idle_shift", sel ? sh_b : sh_a, 0);
  endtask

  initial begin
    int nsh;
    // reset held with TxValid high
    va = 1'b1; da = 8'hA5;
    repeat (3) @(negedge Clk);
    chk("rst_ready", rdy_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_line", line_a, 1);
    chk("rst_load", ld_a, 0);
    chk("rst_shift", sh_a, 0);
    chk("rst_loadin", li_a, 0);
    Reset_n = 1'b1;
    frame(0, 8'hA5, 0, 8'h00);

    // back-to-back with TxValid held, TxData scribbled mid-frame
    va = 1'b1; da = 8'h00;
    frame(0, 8'h00, 1, 8'hFF);
    frame(0, 8'hFF, 0, 8'h00);

    // reset mid-DATA, bit 3 (0x2C bit4 = 0 so the line is low beforehand)
    va = 1'b1; da = 8'h2C;
    @(posedge Clk);
    @(negedge Clk); va = 1'b0;
    repeat (18) @(negedge Clk);
    chk("pre_rst_line", line_a, 0);
    chk("pre_rst_busy", busy_a, 1);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_line", line_a, 1);
    chk("mid_rst_ready", rdy_a, 1);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_shift", sh_a, 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    nsh = 0;
    repeat (6) begin @(negedge Clk); nsh += sh_a; end
    chk("post_rst_shifts", nsh, 0);
    chk("post_rst_line", line_a, 1);
    va = 1'b1; da = 8'h5A;
    frame(0, 8'h5A, 0, 8'h00);

    // two stop bits, three clocks per bit
    vb = 1'b1; db = 8'h80;
    frame(1, 8'h80, 0, 8'h00);

`ifdef SHIFT_FRAME_PARITY_EN
    va = 1'b1; da = 8'h07;
    frame(0, 8'h07, 0, 8'h00);
    vb = 1'b1; db = 8'hA5;
    frame(1, 8'hA5, 0, 8'h00);
    vb = 1'b1; db = 8'h07;
    frame(1, 8'h07, 0, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
